// File: rtl/seq_nonrestoring_divider_if.sv
// Operand/result handshake bundle for the sequential divider.
// Latency: none; these are wires only.
// Backpressure: valid/ready on both the operand and the result side.
interface seq_nonrestoring_divider_if #(
    parameter int WIDTH = 8
);
    // operand side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;

    // result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // producer of operands / consumer of results
    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    // the divider itself
    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_nonrestoring_divider.sv
// Unsigned WIDTH-bit divider, non-restoring recurrence, one quotient bit per clock.
// Latency: WIDTH+1 cycles from accept to out_valid; a zero divisor answers in the next cycle.
// Backpressure: one operation in flight; in_ready low until the result is taken, result held indefinitely.
module seq_nonrestoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    seq_nonrestoring_divider_if.slave   bus,
    output logic                        busy
);

    // The counter only has to reach WIDTH-1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    generate
        if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
            $error("seq_nonrestoring_divider: WIDTH must be in 4..32");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Iteration state: partial remainder (two's complement), dividend
    // shift register, quotient bits being built, latched divisor.
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;

    // Result registers; these only change on a loading edge.
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dbz;

    // Handshake decode.
    logic in_ready;
    logic out_valid;
    logic accept;
    logic release_res;
    logic divisor_zero;

    // Shared adder/subtractor.
    logic             p_neg;
    logic             add_mode;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [WIDTH:0]   add_cin;
    logic [WIDTH:0]   add_sum;

    assign p_neg        = p[WIDTH];
    assign divisor_zero = (bus.divisor == '0);
    assign accept       = bus.in_valid && in_ready;
    assign release_res  = out_valid && bus.out_ready;

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = divisor_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (cnt == LAST_STEP) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // One (WIDTH+1)-bit adder serves both the iteration and the final
    // correction. A non-negative P subtracts D (inverted D plus carry-in),
    // a negative P adds it. The FIX edge only commits the sum when P<0, so
    // the same sign-based mode select is correct there too.
    always_comb begin
        d_ext    = {1'b0, d};
        add_mode = p_neg;
        add_a    = (state == S_FIX) ? p : {p[WIDTH-1:0], a[WIDTH-1]};
        add_b    = add_mode ? d_ext : ~d_ext;
        add_cin  = {{WIDTH{1'b0}}, ~add_mode};
        add_sum  = add_a + add_b + add_cin;
    end

    // Iteration registers: loaded on accept, advanced on every CALC edge,
    // corrected on the FIX edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p   <= '0;
            a   <= '0;
            q   <= '0;
            d   <= '0;
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && !divisor_zero) begin
                        d   <= bus.divisor;
                        a   <= bus.dividend;
                        p   <= '0;
                        q   <= '0;
                        cnt <= '0;
                    end
                end
                S_CALC: begin
                    p   <= add_sum;
                    a   <= {a[WIDTH-2:0], 1'b0};
                    q   <= {q[WIDTH-2:0], ~add_sum[WIDTH]};
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (p_neg) begin
                        p <= add_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: loaded on the FIX edge, or directly on a
    // zero-divisor accept; held otherwise so they stay stable under
    // backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo <= '0;
            rem <= '0;
            dbz <= 1'b0;
        end else begin
            if (state == S_IDLE && accept && divisor_zero) begin
                quo <= '1;
                rem <= bus.dividend;
                dbz <= 1'b1;
            end else if (state == S_FIX) begin
                quo <= q;
                rem <= p_neg ? add_sum[WIDTH-1:0] : p[WIDTH-1:0];
                dbz <= 1'b0;
            end
        end
    end

    // Never ready for operands while a result is pending.
    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !(in_ready && out_valid));

    // A stalled result must not move.
    a_hold_result: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !bus.out_ready) |=>
            (out_valid && $stable(quo) && $stable(rem) && $stable(dbz)));

    // The result is only released through a handshake.
    a_release: assert property (@(posedge clk) disable iff (rst)
        release_res |=> !out_valid);

endmodule
